// File: rtl/ni_flit_packetizer_if.sv
// ---------------------------------------------------------------------------
// ni_flit_packetizer_if
//
// Bundles the processor-side message handshake and the router-side flit
// handshake of the NI flit packetizer.
//
// Parameters:
//   PAYLOAD_FLITS  payload flits per packet; sets the proc_data width (6 bits each)
//
// Signals:
//   proc_valid      processor presents a message
//   proc_ready      packetizer can accept a message this cycle
//   proc_dest       destination node address
//   proc_vc         virtual channel requested at the downstream router
//   proc_data       message payload, 6*PAYLOAD_FLITS bits, chunk 0 in the LSBs
//   flit_out        flit toward the router NI input
//   flit_out_valid  flit_out holds a valid flit
//   noc_ready_in    router accepts the flit this cycle
//
// Modports:
//   slave   the packetizer
//   master  the environment (processor plus router)
// ---------------------------------------------------------------------------
interface ni_flit_packetizer_if #(
    parameter int unsigned PAYLOAD_FLITS = 3
);

    logic                         proc_valid;
    logic                         proc_ready;
    logic [1:0]                   proc_dest;
    logic                         proc_vc;
    logic [6*PAYLOAD_FLITS-1:0]   proc_data;
    logic [7:0]                   flit_out;
    logic                         flit_out_valid;
    logic                         noc_ready_in;

    modport slave (
        input  proc_valid,
        output proc_ready,
        input  proc_dest,
        input  proc_vc,
        input  proc_data,
        output flit_out,
        output flit_out_valid,
        input  noc_ready_in
    );

    modport master (
        output proc_valid,
        input  proc_ready,
        output proc_dest,
        output proc_vc,
        output proc_data,
        input  flit_out,
        input  flit_out_valid,
        output noc_ready_in
    );

endinterface

// File: rtl/ni_flit_packetizer.sv
// ---------------------------------------------------------------------------
// ni_flit_packetizer
//
// Injection side of the per-node network interface. Accepts one message per
// handshake from the processor and serialises it into a head flit followed by
// PAYLOAD_FLITS-1 body flits and one tail flit, each 8 bits, toward the
// router NI input port.
//
// Flit format: [7:6] type (00 idle, 01 head, 10 body, 11 tail)
//   head      : [5:4] dest, [3:2] NODE_ID, [1] vc, [0] 0
//   body/tail : [5:0] payload chunk, chunk k = proc_data[6k+5:6k], LSB first
//
// Parameters:
//   NODE_ID        this node's address, placed in the head source field
//   PAYLOAD_FLITS  body flits plus tail per packet, legal range 2..8
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   bus           ni_flit_packetizer_if.slave (processor and router handshakes)
//   pkt_sent_cnt  [7:0] tail flits transferred, wrapping (only with NI_PKT_CNT_EN)
//
// Optional feature macro: NI_PKT_CNT_EN adds the pkt_sent_cnt output and its
// counter. Without it the block is otherwise identical.
// ---------------------------------------------------------------------------
module ni_flit_packetizer #(
    parameter logic [1:0]  NODE_ID       = 2'b00,
    parameter int unsigned PAYLOAD_FLITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    ni_flit_packetizer_if.slave  bus
`ifdef NI_PKT_CNT_EN
    ,
    output logic [7:0]           pkt_sent_cnt
`endif
);

    localparam int unsigned DataW       = 6 * PAYLOAD_FLITS;
    localparam logic [2:0]  LastBodyIdx = 3'(PAYLOAD_FLITS - 2);

    // FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HEAD = 2'd1;
    localparam logic [1:0] BODY = 2'd2;
    localparam logic [1:0] TAIL = 2'd3;

    // Flit type field
    localparam logic [1:0] TypeHead = 2'b01;
    localparam logic [1:0] TypeBody = 2'b10;
    localparam logic [1:0] TypeTail = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [1:0]       dest_q, dest_d;
    logic             vc_q, vc_d;
    logic [DataW-1:0] data_q, data_d;

    logic             ready;
    logic             accept;
    logic             flit_valid;
    logic [7:0]       flit;
    logic             xfer;
    logic [5:0]       body_chunk;
    logic [5:0]       tail_chunk;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // proc_ready looks at rst directly so it is low for the whole reset
    // window and rises combinationally as soon as rst deasserts.
    assign ready  = rst && (state_q == IDLE);
    assign accept = bus.proc_valid && ready;
    // noc_ready_in while nothing is presented is simply ignored.
    assign xfer   = flit_valid && bus.noc_ready_in;

    assign bus.proc_ready     = ready;
    assign bus.flit_out       = flit;
    assign bus.flit_out_valid = flit_valid;

    // ------------------------------------------------------------------
    // Payload chunk selection
    // ------------------------------------------------------------------
    always_comb begin
        body_chunk = 6'd0;
        for (int unsigned k = 0; k < PAYLOAD_FLITS - 1; k++) begin
            if (idx_q == k[2:0]) begin
                body_chunk = data_q[6*k +: 6];
            end
        end
    end

    // The tail always carries the last chunk; the index parks at
    // PAYLOAD_FLITS-2 in TAIL and is not used there.
    assign tail_chunk = data_q[DataW-1 -: 6];

    // ------------------------------------------------------------------
    // Flit output, decoded from registered state only, so it holds steady
    // for as long as the router stalls.
    // ------------------------------------------------------------------
    always_comb begin
        flit       = 8'h00;
        flit_valid = 1'b0;
        case (state_q)
            HEAD: begin
                flit       = {TypeHead, dest_q, NODE_ID, vc_q, 1'b0};
                flit_valid = 1'b1;
            end
            BODY: begin
                flit       = {TypeBody, body_chunk};
                flit_valid = 1'b1;
            end
            TAIL: begin
                flit       = {TypeTail, tail_chunk};
                flit_valid = 1'b1;
            end
            default: begin
                flit       = 8'h00;
                flit_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dest_d  = dest_q;
        vc_d    = vc_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Capture everything; processor inputs are don't-care
                    // for the rest of the packet.
                    dest_d  = bus.proc_dest;
                    vc_d    = bus.proc_vc;
                    data_d  = bus.proc_data;
                    idx_d   = 3'd0;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (xfer) begin
                    idx_d   = 3'd0;
                    state_d = BODY;
                end
            end
            BODY: begin
                if (xfer) begin
                    if (idx_q == LastBodyIdx) begin
                        state_d = TAIL;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            TAIL: begin
                if (xfer) begin
                    idx_d   = 3'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            dest_q  <= 2'd0;
            vc_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dest_q  <= dest_d;
            vc_q    <= vc_d;
            data_q  <= data_d;
        end
    end

`ifdef NI_PKT_CNT_EN
    // ------------------------------------------------------------------
    // Sent-packet counter: one count per tail transfer, wraps at 8 bits.
    // ------------------------------------------------------------------
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == TAIL) && xfer) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_sent_cnt = cnt_q;
`endif

endmodule

// File: doc/ni_flit_packetizer.md
Name: ni_flit_packetizer

Overview:
- Injection side of the per-node network interface.
- Accepts one message per handshake from the processor and serialises it into head, body and tail 8-bit flits.
- Drives the router's NI input port, using a valid/ready handshake toward the router.
- Acts as the transmitter counterpart of the router's ejection output toward the processor.

Parameters:
- NODE_ID, 2'b00, this node's 2-bit address, inserted into the head flit source field.
- PAYLOAD_FLITS, 3, number of payload flits per packet (body flits plus tail). Legal range 2..8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- proc_valid  input  1  processor presents a message.
- proc_ready  output  1  block can accept a message this cycle.
- proc_dest  input  2  destination node address.
- proc_vc  input  1  virtual channel to request at the downstream router.
- proc_data  input  6*PAYLOAD_FLITS  message payload.
- flit_out  output  8  flit to the router NI input.
- flit_out_valid  output  1  flit_out holds a valid flit.
- noc_ready_in  input  1  router accepts the flit this cycle.

Behaviour:
- Flit format:
  - [7:6] type: 00 idle, 01 head, 10 body, 11 tail.
  - Head: [5:4] dest, [3:2] NODE_ID, [1] vc, [0] 0.
  - Body/tail: [5:0] payload chunk.
- Chunk order: chunk k = proc_data[6k+5:6k], LSB chunk first.
  - Chunks 0..PAYLOAD_FLITS-2 go out as body flits.
  - Chunk PAYLOAD_FLITS-1 goes out as the tail flit.
- Message accept: occurs when proc_valid && proc_ready at a clock edge.
  - dest, vc and data are captured into internal registers.
  - Processor inputs are don't-care afterwards.
- Flit transfer: occurs when flit_out_valid && noc_ready_in at a clock edge.
- Stability: while flit_out_valid=1 and noc_ready_in=0, flit_out and flit_out_valid hold stable. Valid is never withdrawn before transfer.
- FSM states IDLE, HEAD, BODY, TAIL:
  - IDLE: proc_ready=1, flit_out_valid=0, flit_out=8'h00. On accept, go to HEAD.
  - HEAD: present the head flit. On transfer, go to BODY with chunk index=0.
  - BODY: present the body flit for the current index.
    - On transfer, increment the index.
    - When the index reaches PAYLOAD_FLITS-2 at transfer, go to TAIL.
  - TAIL: present the tail flit. On transfer, go to IDLE.
- Latency:
  - Head flit is valid on the cycle after accept.
  - With noc_ready_in held at 1, one flit transfers per cycle: PAYLOAD_FLITS+1 cycles per packet.
  - One bubble cycle in IDLE separates packets (proc_ready is asserted only in IDLE).
- Chunk index width: 3 bits; counts 0..PAYLOAD_FLITS-2 and never wraps within a packet.
- dest == NODE_ID: packet is sent normally; no local short-circuit.
- noc_ready_in asserted while flit_out_valid=0: ignored.
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - flit_out=8'h00, flit_out_valid=0, chunk index=0, captured registers=0.
  - proc_ready is forced to 0 while rst is low, and rises to 1 combinationally once rst deasserts.
- Reset mid-packet: the partial packet is discarded and is not resumed. The system resets the router together with the NI.

Optional Feature:
- Macro: NI_PKT_CNT_EN.
- When defined:
  - Adds output pkt_sent_cnt [7:0], reset to 0.
  - Increments by 1 on each tail flit transfer.
  - Wraps 8'hFF -> 8'h00.
- When undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic packet. Setup: NODE_ID=0, PAYLOAD_FLITS=3, noc_ready_in=1. Stimulus: accept dest=2, vc=1, data=18'h2A563. Required response, on consecutive cycles: 8'h62, 8'hA3, 8'h95, 8'hEA; then flit_out_valid=0 and proc_ready=1.
- Backpressure. Stimulus: same packet, noc_ready_in=0 for 3 cycles during the first body flit. Required response: flit_out holds 8'hA3 with valid=1 for all 3 cycles; no flit is skipped or duplicated.
- Back-to-back messages. Stimulus: proc_valid held high with two messages. Required response: exactly one IDLE cycle between tail 8'hEA and the next head; second message captured correctly; inputs changed after accept do not alter flits in flight.
- Reset mid-packet. Stimulus: assert rst low during the body flit, asynchronously between edges. Required response: flit_out_valid=0 and flit_out=8'h00 immediately; after release, proc_ready=1 and the next packet starts with a head flit.
- Self-addressed and minimum size. Setup: PAYLOAD_FLITS=2, NODE_ID=2'b01. Stimulus: dest=1, vc=0, data=12'hFC0. Required response: 8'h54, 8'h80, 8'hFF.
- Counter (NI_PKT_CNT_EN defined). Stimulus: send 257 packets. Required response: pkt_sent_cnt=8'h01, having wrapped through 8'h00 at the 256th tail.
